// File: rtl/shreg_seq_ctrl_pkg.sv
// Shared constants and types for the universal shift register sequencer.
package shreg_seq_ctrl_pkg;

  localparam int unsigned DATA_W = 4;

  // Register mode encodings
  localparam logic [1:0] MODE_SHIFT = 2'b00;
  localparam logic [1:0] MODE_ROT   = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  // Register direction encodings
  localparam logic DIR_TO_MSB = 1'b0;
  localparam logic DIR_TO_LSB = 1'b1;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_STEP = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Command fields held for the duration of a sequence
  typedef struct packed {
    logic              rot;
    logic              dir;
    logic              fill;
    logic [DATA_W-1:0] data;
  } cmd_t;

  // Register mode used while stepping
  function automatic logic [1:0] step_mode(input logic rot);
    return rot ? MODE_ROT : MODE_SHIFT;
  endfunction

endpackage

// File: rtl/shreg_seq_ctrl_step_cnt.sv
// Loadable down-counter tracking the remaining shift/rotate steps.
module shreg_step_cnt #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             last,
  output logic             zero
);

  // Count register: load wins over decrement, never wraps below zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !zero) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign last = (cnt == CNT_W'(1));
  assign zero = (cnt == '0);

endmodule

// File: rtl/shreg_seq_ctrl.sv
// Sequencer driving a 4-bit universal shift register for an exact step count.
module shreg_seq_ctrl
  import shreg_seq_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_load,
  input  logic              cmd_rot,
  input  logic              cmd_dir,
  input  logic              cmd_fill,
  input  logic [CNT_W-1:0]  cmd_cnt,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              abort,
  output logic              reg_enb,
  output logic [1:0]        reg_mode,
  output logic              reg_dir,
  output logic [DATA_W-1:0] reg_d,
  output logic              reg_sin,
  output logic              done,
  output logic              aborted
);

  state_e           state_q;
  state_e           state_d;
  cmd_t             cmd_q;
  logic             aborted_q;
  logic             aborted_d;
  logic             cmd_latch_c;
  logic             cnt_dec_c;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_last;
  logic             cnt_zero;

  shreg_step_cnt #(
    .CNT_W (CNT_W)
  ) u_step_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cmd_latch_c),
    .load_val (cmd_cnt),
    .dec      (cnt_dec_c),
    .cnt      (cnt_q),
    .last     (cnt_last),
    .zero     (cnt_zero)
  );

  // State, latched command and abort flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aborted_q <= aborted_d;
      if (cmd_latch_c) begin
        cmd_q <= '{rot: cmd_rot, dir: cmd_dir, fill: cmd_fill, data: cmd_data};
      end
    end
  end

  // Next-state logic and output decode from the state/command flops
  always_comb begin
    state_d     = state_q;
    aborted_d   = aborted_q;
    cmd_latch_c = 1'b0;
    cnt_dec_c   = 1'b0;
    cmd_ready   = 1'b0;
    reg_enb     = 1'b0;
    reg_mode    = MODE_HOLD;
    reg_dir     = DIR_TO_MSB;
    reg_d       = cmd_q.data;
    reg_sin     = 1'b0;
    done        = 1'b0;
    aborted     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cmd_latch_c = 1'b1;
          if (cmd_load) begin
            state_d = ST_LOAD;
          end else if (cmd_cnt != '0) begin
            state_d = ST_STEP;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_LOAD: begin
        reg_enb  = 1'b1;
        reg_mode = MODE_LOAD;
        state_d  = cnt_zero ? ST_DONE : ST_STEP;
      end

      // The step at an aborting edge still happens; only later steps are dropped
      ST_STEP: begin
        reg_enb   = 1'b1;
        reg_mode  = step_mode(cmd_q.rot);
        reg_dir   = cmd_q.dir;
        reg_sin   = cmd_q.fill & ~cmd_q.rot;
        cnt_dec_c = 1'b1;
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DONE;
        end else if (cnt_last) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done      = 1'b1;
        aborted   = aborted_q;
        aborted_d = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Counter value is consumed only through its last/zero flags
  logic unused_cnt;
  assign unused_cnt = ^cnt_q;

endmodule

// File: tb/tb_shreg_seq_ctrl.sv
// Self-checking bench for shreg_seq_ctrl with a behavioural 4-bit register.
module tb_shreg_seq_ctrl;
  import shreg_seq_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic       cmd_rot;
  logic       cmd_dir;
  logic       cmd_fill;
  logic [2:0] cmd_cnt;
  logic [3:0] cmd_data;
  logic       abort;
  logic       reg_enb;
  logic [1:0] reg_mode;
  logic       reg_dir;
  logic [3:0] reg_d;
  logic       reg_sin;
  logic       done;
  logic       aborted;

  int n_checks = 0;
  int n_errors = 0;

  shreg_seq_ctrl #(.CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_load  (cmd_load),
    .cmd_rot   (cmd_rot),
    .cmd_dir   (cmd_dir),
    .cmd_fill  (cmd_fill),
    .cmd_cnt   (cmd_cnt),
    .cmd_data  (cmd_data),
    .abort     (abort),
    .reg_enb   (reg_enb),
    .reg_mode  (reg_mode),
    .reg_dir   (reg_dir),
    .reg_d     (reg_d),
    .reg_sin   (reg_sin),
    .done      (done),
    .aborted   (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural universal shift register driven by the controller
  logic [3:0] q;
  logic       preload_en;
  logic [3:0] preload_val;

  always @(posedge clk) begin
    if (preload_en) begin
      q <= preload_val;
    end else if (reg_enb) begin
      case (reg_mode)
        MODE_SHIFT: q <= (reg_dir == DIR_TO_LSB) ? {reg_sin, q[3:1]} : {q[2:0], reg_sin};
        MODE_ROT:   q <= (reg_dir == DIR_TO_LSB) ? {q[0], q[3:1]} : {q[2:0], q[3]};
        MODE_LOAD:  q <= reg_d;
        default:    q <= q;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       load;
    logic       rot;
    logic       dir;
    logic       fill;
    logic [2:0] cnt;
    logic [3:0] data;
    logic       pre;
    logic [3:0] pre_val;
    int         abort_at;
    logic       abort_in_load;
    logic [3:0] exp_q;
  } vec_t;

  vec_t vecs[9];

  // Runs one command from an idle negedge and checks every cycle until back in IDLE
  task automatic run_vec(input int idx, input vec_t v);
    int neff;
    int l;
    logic exp_ab;
    neff   = (v.abort_at != 0) ? v.abort_at : int'(v.cnt);
    l      = v.load ? 1 : 0;
    exp_ab = (v.abort_at != 0);
    if (v.pre) begin
      preload_en  = 1'b1;
      preload_val = v.pre_val;
      @(negedge clk);
      preload_en  = 1'b0;
    end
    cmd_load  = v.load;
    cmd_rot   = v.rot;
    cmd_dir   = v.dir;
    cmd_fill  = v.fill;
    cmd_cnt   = v.cnt;
    cmd_data  = v.data;
    cmd_valid = 1'b1;
    chk($sformatf("v%0d ready_idle", idx), 32'(cmd_ready), 32'(1));
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 1; k <= l + neff + 1; k++) begin
      abort = 1'b0;
      if (k == 1 && l == 1 && v.abort_in_load) abort = 1'b1;
      if (v.abort_at != 0 && k == l + v.abort_at) abort = 1'b1;
      chk($sformatf("v%0d c%0d ready", idx, k), 32'(cmd_ready), 32'(0));
      if (k <= l) begin
        chk($sformatf("v%0d c%0d enb", idx, k), 32'(reg_enb), 32'(1));
        chk($sformatf("v%0d c%0d mode", idx, k), 32'(reg_mode), 32'(MODE_LOAD));
        chk($sformatf("v%0d c%0d d", idx, k), 32'(reg_d), 32'(v.data));
        chk($sformatf("v%0d c%0d done", idx, k), 32'(done), 32'(0));
      end else if (k <= l + neff) begin
        chk($sformatf("v%0d c%0d enb", idx, k), 32'(reg_enb), 32'(1));
        chk($sformatf("v%0d c%0d mode", idx, k), 32'(reg_mode),
            32'(v.rot ? MODE_ROT : MODE_SHIFT));
        chk($sformatf("v%0d c%0d dir", idx, k), 32'(reg_dir), 32'(v.dir));
        chk($sformatf("v%0d c%0d sin", idx, k), 32'(reg_sin), 32'(v.rot ? 1'b0 : v.fill));
        chk($sformatf("v%0d c%0d done", idx, k), 32'(done), 32'(0));
      end else begin
        chk($sformatf("v%0d c%0d enb", idx, k), 32'(reg_enb), 32'(0));
        chk($sformatf("v%0d c%0d mode", idx, k), 32'(reg_mode), 32'(MODE_HOLD));
        chk($sformatf("v%0d c%0d done", idx, k), 32'(done), 32'(1));
        chk($sformatf("v%0d c%0d aborted", idx, k), 32'(aborted), 32'(exp_ab));
      end
      @(negedge clk);
    end
    abort = 1'b0;
    chk($sformatf("v%0d ready_after", idx), 32'(cmd_ready), 32'(1));
    chk($sformatf("v%0d done_after", idx), 32'(done), 32'(0));
    chk($sformatf("v%0d aborted_after", idx), 32'(aborted), 32'(0));
    chk($sformatf("v%0d reg_q", idx), 32'(q), 32'(v.exp_q));
  endtask

  initial begin
    logic [7:0] enb_pat;
    logic [7:0] rdy_pat;
    logic [7:0] done_pat;

    //          load rot dir fill cnt   data     pre  pre_val  ab ail exp_q
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 4'b1011, 1'b0, 4'b0000, 0, 1'b0, 4'b1100};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd5, 4'b0000, 1'b1, 4'b1000, 0, 1'b0, 4'b0100};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'b1111, 1'b1, 4'b0101, 0, 1'b0, 4'b0101};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 4'b0001, 1'b0, 4'b0000, 3, 1'b0, 4'b1111};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 4'b1001, 1'b0, 4'b0000, 0, 1'b0, 4'b1001};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 4'b0110, 1'b0, 4'b0000, 0, 1'b0, 4'b0110};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 4'b0000, 1'b1, 4'b1111, 0, 1'b0, 4'b0001};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 4'b1100, 1'b0, 4'b0000, 0, 1'b1, 4'b1111};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 4'b1010, 1'b0, 4'b0000, 1, 1'b0, 4'b0101};

    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_load    = 1'b0;
    cmd_rot     = 1'b0;
    cmd_dir     = 1'b0;
    cmd_fill    = 1'b0;
    cmd_cnt     = 3'd0;
    cmd_data    = 4'd0;
    abort       = 1'b0;
    preload_en  = 1'b0;
    preload_val = 4'd0;

    // Reset values
    #1;
    chk("rst ready", 32'(cmd_ready), 32'(1));
    chk("rst enb", 32'(reg_enb), 32'(0));
    chk("rst mode", 32'(reg_mode), 32'(MODE_HOLD));
    chk("rst dir", 32'(reg_dir), 32'(0));
    chk("rst d", 32'(reg_d), 32'(0));
    chk("rst sin", 32'(reg_sin), 32'(0));
    chk("rst done", 32'(done), 32'(0));
    chk("rst aborted", 32'(aborted), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_vec(i, vecs[i]);
    end

    // Asynchronous reset in the middle of a rotate sequence
    cmd_load  = 1'b0;
    cmd_rot   = 1'b1;
    cmd_dir   = 1'b0;
    cmd_fill  = 1'b0;
    cmd_cnt   = 3'd7;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("midrst enb_before", 32'(reg_enb), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("midrst enb", 32'(reg_enb), 32'(0));
    chk("midrst mode", 32'(reg_mode), 32'(MODE_HOLD));
    chk("midrst ready", 32'(cmd_ready), 32'(1));
    chk("midrst done", 32'(done), 32'(0));
    #1 rst = 1'b0;
    cmd_rot   = 1'b0;
    cmd_cnt   = 3'd0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("postrst done", 32'(done), 32'(1));
    chk("postrst aborted", 32'(aborted), 32'(0));
    chk("postrst ready", 32'(cmd_ready), 32'(0));
    @(negedge clk);
    chk("postrst ready_again", 32'(cmd_ready), 32'(1));

    // Back-to-back commands with cmd_valid held high
    enb_pat  = 8'b0011_0011;
    rdy_pat  = 8'b1000_1000;
    done_pat = 8'b0100_0100;
    cmd_load  = 1'b1;
    cmd_rot   = 1'b0;
    cmd_dir   = DIR_TO_MSB;
    cmd_fill  = 1'b0;
    cmd_cnt   = 3'd1;
    cmd_data  = 4'b0011;
    cmd_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("b2b c%0d enb", k + 1), 32'(reg_enb), 32'(enb_pat[k]));
      chk($sformatf("b2b c%0d ready", k + 1), 32'(cmd_ready), 32'(rdy_pat[k]));
      chk($sformatf("b2b c%0d done", k + 1), 32'(done), 32'(done_pat[k]));
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b idle enb", 32'(reg_enb), 32'(0));
    chk("b2b reg_q", 32'(q), 32'(4'b0110));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

endmodule
